seg_scan_ctrl: RTL and testbench

Parametrised multiplexed 7-segment display scanner, the successor to the fixed 3-to-8 digit-select decoder. It contains its own scan prescaler and digit counter, a per-digit enable mask (replaces hard-wired blanked positions), a global power enable, and an anti-ghosting blank interval. It also performs hex-to-segment decode. It sits between the register/counter logic that produces digit values and the board's common-anode display pins.

---
 rtl/seg_pkg.sv | 36 +++
 rtl/hex7seg.sv | 40 ++++
 rtl/seg_scan_ctrl.sv | 124 ++++++++++++
 tb/tb_seg_scan_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// -----------------------------------------------------------------------------
// seg_pkg
//   Shared definitions for the multiplexed 7-segment display scanner.
//   - SEG_0 .. SEG_F : active-high segment patterns {g,f,e,d,c,b,a} for 0..F
//   - SEG_OFF        : full 8-bit active-low "all dark" pattern (dp + g..a)
//   - digit_idx_width: width of a digit index for a given digit count
// -----------------------------------------------------------------------------
package seg_pkg;

  // Active-high segment patterns, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h7C;  // lower-case b
  localparam logic [6:0] SEG_C = 7'h39;
  localparam logic [6:0] SEG_D = 7'h5E;  // lower-case d
  localparam logic [6:0] SEG_E = 7'h79;
  localparam logic [6:0] SEG_F = 7'h71;

  // Active-low {dp, g..a} with every segment dark.
  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Width of a digit index; never narrower than one bit.
  function automatic int digit_idx_width(input int num_digits);
    return (num_digits < 2) ? 1 : $clog2(num_digits);
  endfunction

endpackage : seg_pkg

// File: rtl/hex7seg.sv
// -----------------------------------------------------------------------------
// hex7seg
//   Combinational hex nibble to 7-segment decoder, active-high outputs.
//   Ports:
//     nibble  in  4  hex value 0..F
//     seg     out 7  segment pattern {g,f,e,d,c,b,a}, 1 = segment lit
// -----------------------------------------------------------------------------
module hex7seg
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    // NOTE: a default before the case keeps every path assigned, so no latch
    // is inferred even if the case were ever made incomplete.
    seg = SEG_0;
    case (nibble)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_0;
    endcase
  end

endmodule : hex7seg

// File: rtl/seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg_scan_ctrl
//   Multiplexed common-anode 7-segment display scanner. A prescaler divides
//   clk into digit slots of DIV cycles; the digit index walks 0..NUM_DIGITS-1
//   one slot at a time. The first BLANK cycles of each slot keep every select
//   off so the previous digit's segments cannot ghost onto the next digit.
//   Masked digits still consume their slot, keeping the duty cycle equal.
//
//   Parameters:
//     NUM_DIGITS  number of multiplexed digits (2..16)
//     IDX_W       digit index width
//     DIV         clk cycles per digit slot (>= 2)
//     DIV_W       prescaler width
//     BLANK       blank cycles at slot start (0 <= BLANK < DIV)
//
//   Ports:
//     clk         in  1             system clock, rising edge
//     rst         in  1             synchronous active-high reset
//     power_en    in  1             0 = display dark, scan held at digit 0
//     digit_en    in  NUM_DIGITS    bit i = digit i shown
//     digit_data  in  4*NUM_DIGITS  hex nibble of digit i at [4i+3:4i]
//     dp_in       in  NUM_DIGITS    decimal point per digit, 1 = lit
//     sel         out NUM_DIGITS    digit select, active-low, registered
//     seg         out 8             {dp,g,f,e,d,c,b,a}, active-low, registered
//     cur_digit   out IDX_W         slot currently being scanned
//     frame_tick  out 1             one-cycle pulse when the index wraps to 0
// -----------------------------------------------------------------------------
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int IDX_W      = digit_idx_width(NUM_DIGITS),
  parameter int DIV        = 100000,
  parameter int DIV_W      = $clog2(DIV),
  parameter int BLANK      = 1000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    power_en,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [4*NUM_DIGITS-1:0] digit_data,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [NUM_DIGITS-1:0]   sel,
  output logic [7:0]              seg,
  output logic [IDX_W-1:0]        cur_digit,
  output logic                    frame_tick
);

  localparam logic [DIV_W-1:0] PRE_LAST  = DIV_W'(DIV - 1);
  localparam logic [DIV_W-1:0] BLANK_CNT = DIV_W'(BLANK);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  logic [DIV_W-1:0]      prescaler;
  logic                  slot_end;
  logic                  idx_last;
  logic                  past_blank;
  logic                  lit;
  logic [3:0]            nibble;
  logic [6:0]            seg_hex;
  logic [NUM_DIGITS-1:0] sel_onehot;

  assign slot_end = (prescaler == PRE_LAST);
  assign idx_last = (cur_digit == IDX_LAST);

  // With no blank interval the select is live for the whole slot; handled
  // structurally so the comparator against zero never exists.
  if (BLANK == 0) begin : g_no_blank
    assign past_blank = 1'b1;
  end else begin : g_blank
    assign past_blank = (prescaler >= BLANK_CNT);
  end

  // Digit lit this cycle: display powered, digit unmasked, blank interval over.
  assign lit = power_en && digit_en[cur_digit] && past_blank;

  // Nibble of the current digit; {idx,2'b00} is idx*4.
  assign nibble = digit_data[{cur_digit, 2'b00} +: 4];

  always_comb begin
    sel_onehot            = '0;
    sel_onehot[cur_digit] = 1'b1;
  end

  hex7seg u_hex7seg (
    .nibble (nibble),
    .seg    (seg_hex)
  );

  // Prescaler, digit index, frame pulse and the registered display outputs.
  always_ff @(posedge clk) begin
    // NOTE: all state uses non-blocking assignments; frame_tick gets a default
    // of 0 below and a later assignment in the same pass overrides it.
    if (rst) begin
      prescaler  <= '0;
      cur_digit  <= '0;
      frame_tick <= 1'b0;
      sel        <= '1;
      seg        <= SEG_OFF;
    end else begin
      // Outputs follow the current slot state with one cycle of latency.
      sel <= lit ? ~sel_onehot : '1;
      seg <= lit ? {~dp_in[cur_digit], ~seg_hex} : SEG_OFF;

      frame_tick <= 1'b0;
      if (!power_en) begin
        // Hold the scan at the start of digit 0 so power-up begins with a
        // blank interval and no frame pulse.
        prescaler <= '0;
        cur_digit <= '0;
      end else if (slot_end) begin
        prescaler <= '0;
        if (idx_last) begin
          cur_digit  <= '0;
          frame_tick <= 1'b1;
        end else begin
          cur_digit <= cur_digit + IDX_W'(1);
        end
      end else begin
        prescaler <= prescaler + DIV_W'(1);
      end
    end
  end

endmodule : seg_scan_ctrl

// File: tb/tb_seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_ctrl
//   Directed bench for seg_scan_ctrl with DIV=4, BLANK=1. Two instances run in
//   lock-step on the same clock, reset and power: an 8-digit one and a 4-digit
//   one. k counts clock edges since the scan last restarted (reset release or
//   power-up); after edge k the state is prescaler=k%4, digit=(k/4)%N, and
//   the outputs reflect the state after edge k-1.
// -----------------------------------------------------------------------------
module tb_seg_scan_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        power_en;

  logic [7:0]  en8;
  logic [31:0] data8;
  logic [7:0]  dp8;
  logic [7:0]  sel8;
  logic [7:0]  seg8;
  logic [2:0]  cur8;
  logic        ft8;

  logic [3:0]  en4;
  logic [15:0] data4;
  logic [3:0]  dp4;
  logic [3:0]  sel4;
  logic [7:0]  seg4;
  logic [1:0]  cur4;
  logic        ft4;

  seg_scan_ctrl #(.NUM_DIGITS(8), .DIV(4), .BLANK(1)) dut8 (
    .clk        (clk),
    .rst        (rst),
    .power_en   (power_en),
    .digit_en   (en8),
    .digit_data (data8),
    .dp_in      (dp8),
    .sel        (sel8),
    .seg        (seg8),
    .cur_digit  (cur8),
    .frame_tick (ft8)
  );

  seg_scan_ctrl #(.NUM_DIGITS(4), .DIV(4), .BLANK(1)) dut4 (
    .clk        (clk),
    .rst        (rst),
    .power_en   (power_en),
    .digit_en   (en4),
    .digit_data (data4),
    .dp_in      (dp4),
    .sel        (sel4),
    .seg        (seg4),
    .cur_digit  (cur4),
    .frame_tick (ft4)
  );

  int checks   = 0;
  int failures = 0;
  int k        = 0;
  int ft8_cnt  = 0;
  int ft4_cnt  = 0;

  // Expected active-low seg per digit for the 8-digit instance, and its mask.
  logic [7:0] exp_seg8 [8];
  logic [7:0] exp_en8;
  // Expected seg for digits 0..3 of data 3210, dp off (4-digit instance).
  logic [7:0] exp_seg4 [4];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_dark(input string tag);
    check({tag, " sel8"}, 32'(sel8), 32'hFF);
    check({tag, " seg8"}, 32'(seg8), 32'hFF);
    check({tag, " cur8"}, 32'(cur8), 32'd0);
    check({tag, " ft8"},  32'(ft8),  32'd0);
    check({tag, " sel4"}, 32'(sel4), 32'hF);
    check({tag, " seg4"}, 32'(seg4), 32'hFF);
    check({tag, " cur4"}, 32'(cur4), 32'd0);
    check({tag, " ft4"},  32'(ft4),  32'd0);
  endtask

  // Advance n edges, checking both instances against the slot timing.
  task automatic run_edges(input int n);
    for (int i = 0; i < n; i++) begin
      int         pp;
      int         d8;
      int         d4;
      logic [7:0] esel8;
      logic [7:0] eseg8;
      logic [3:0] esel4;
      logic [7:0] eseg4;
      step();
      k++;
      pp = (k - 1) % 4;
      d8 = ((k - 1) / 4) % 8;
      d4 = ((k - 1) / 4) % 4;
      if (exp_en8[d8] && pp >= 1) begin
        esel8 = ~(8'd1 << d8);
        eseg8 = exp_seg8[d8];
      end else begin
        esel8 = 8'hFF;
        eseg8 = 8'hFF;
      end
      if (pp >= 1) begin
        esel4 = ~(4'd1 << d4);
        eseg4 = exp_seg4[d4];
      end else begin
        esel4 = 4'hF;
        eseg4 = 8'hFF;
      end
      if (ft8) ft8_cnt++;
      if (ft4) ft4_cnt++;
      check($sformatf("sel8 k=%0d", k), 32'(sel8), 32'(esel8));
      check($sformatf("seg8 k=%0d", k), 32'(seg8), 32'(eseg8));
      check($sformatf("cur8 k=%0d", k), 32'(cur8), 32'((k / 4) % 8));
      check($sformatf("ft8 k=%0d", k),  32'(ft8),  32'((k % 32) == 0));
      check($sformatf("sel4 k=%0d", k), 32'(sel4), 32'(esel4));
      check($sformatf("seg4 k=%0d", k), 32'(seg4), 32'(eseg4));
      check($sformatf("cur4 k=%0d", k), 32'(cur4), 32'((k / 4) % 4));
      check($sformatf("ft4 k=%0d", k),  32'(ft4),  32'((k % 16) == 0));
    end
  endtask

  initial begin
    exp_seg8[0] = 8'hC0; exp_seg8[1] = 8'hF9; exp_seg8[2] = 8'hA4;
    exp_seg8[3] = 8'hB0; exp_seg8[4] = 8'h99; exp_seg8[5] = 8'h92;
    exp_seg8[6] = 8'h82; exp_seg8[7] = 8'hF8;
    exp_seg4[0] = 8'hC0; exp_seg4[1] = 8'hF9; exp_seg4[2] = 8'hA4;
    exp_seg4[3] = 8'hB0;
    exp_en8     = 8'hFF;

    rst      = 1'b1;
    power_en = 1'b1;
    en8      = 8'hFF;
    data8    = 32'h7654_3210;
    dp8      = 8'h00;
    en4      = 4'hF;
    data4    = 16'h3210;
    dp4      = 4'h0;

    // Reset held for three cycles with power on.
    repeat (3) begin
      step();
      check_dark("rst_hold");
    end

    // Release reset: full scans; first select FE at k=2 (BLANK+1).
    rst = 1'b0;
    k   = 0;
    run_edges(64);
    check("ft8 pulses in 64 cycles", 32'(ft8_cnt), 32'd2);
    check("ft4 pulses in 64 cycles", 32'(ft4_cnt), 32'd4);

    // Mask digits 2 and 5; timing unchanged.
    en8     = 8'b1101_1011;
    exp_en8 = 8'b1101_1011;
    run_edges(32);

    // Decode and decimal point on digit 0: 8 with dp -> 00.
    en8         = 8'hFF;
    exp_en8     = 8'hFF;
    data8       = 32'h7654_3218;
    dp8         = 8'h01;
    exp_seg8[0] = 8'h00;
    run_edges(32);

    // F without dp -> 8E.
    data8       = 32'h7654_321F;
    dp8         = 8'h00;
    exp_seg8[0] = 8'h8E;
    run_edges(32);

    // b -> 83.
    data8       = 32'h7654_321B;
    exp_seg8[0] = 8'h83;
    run_edges(32);

    data8       = 32'h7654_3210;
    exp_seg8[0] = 8'hC0;

    // Move into slot 5 (k=192 is a frame start), then drop power.
    run_edges(21);
    check("cur8 before power drop", 32'(cur8), 32'd5);
    power_en = 1'b0;
    repeat (3) begin
      step();
      check_dark("power_off");
    end

    // Power back: restart at digit 0 with blank, no early frame pulse.
    power_en = 1'b1;
    k        = 0;
    run_edges(45);

    // Reset in the middle of slot 3.
    check("cur8 before mid reset", 32'(cur8), 32'd3);
    rst = 1'b1;
    step();
    check_dark("rst_mid");
    rst = 1'b0;
    k   = 0;
    run_edges(32);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_seg_scan_ctrl
